// File: rtl/bitcell_array_ctrl.sv
// Bitcell array sequencer: takes single-word read/write requests and runs a
// setup/access/hold sequence on the array's sel/rw/in lines, then returns a response.
module bitcell_array_ctrl #(
  parameter int unsigned ADDR_W        = 2,
  parameter int unsigned DATA_W        = 4,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic [(2**ADDR_W)-1:0]  arr_sel,
  output logic                    arr_rw,
  output logic [DATA_W-1:0]       arr_in,
  input  logic [DATA_W-1:0]       arr_out
);

  localparam int unsigned WORDS = 2**ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RESP} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               req_ready_n, rsp_valid_n, arr_rw_n;
  logic [DATA_W-1:0]  rdata_n, arr_in_n;
  logic [WORDS-1:0]   arr_sel_n;

  // Next state plus next value of every registered output.
  // arr_rw/arr_in double as the latched request type and write data.
  always_comb begin
    state_n  = state;
    addr_n   = addr_q;
    cnt_n    = cnt;
    arr_rw_n = arr_rw;
    arr_in_n = arr_in;
    rdata_n  = rsp_rdata;

    case (state)
      IDLE: begin
        if (req_valid) begin
          state_n  = SETUP;
          addr_n   = req_addr;
          arr_rw_n = req_we;
          arr_in_n = req_we ? req_wdata : '0;
          rdata_n  = '0;
        end
      end
      SETUP: begin
        state_n = ACCESS;
        cnt_n   = CNT_W'(ACCESS_CYCLES - 1);
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_n = HOLD;
          if (!arr_rw) rdata_n = arr_out;
        end else begin
          cnt_n = CNT_W'(cnt - 1'b1);
        end
      end
      HOLD: state_n = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_n  = IDLE;
          arr_rw_n = 1'b0;
          arr_in_n = '0;
          rdata_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    req_ready_n = (state_n == IDLE);
    rsp_valid_n = (state_n == RESP);
    arr_sel_n   = (state_n == ACCESS) ? (WORDS'(1) << addr_n) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      arr_sel   <= '0;
      arr_rw    <= 1'b0;
      arr_in    <= '0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      cnt       <= cnt_n;
      req_ready <= req_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rdata_n;
      arr_sel   <= arr_sel_n;
      arr_rw    <= arr_rw_n;
      arr_in    <= arr_in_n;
    end
  end

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Directed bench for bitcell_array_ctrl: three instances (ACCESS_CYCLES 2, 1, 15),
// each driving a small behavioural bitcell array.
module tb_bitcell_array_ctrl;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid [NI];
  logic       req_we;
  logic [1:0] req_addr;
  logic [3:0] req_wdata;
  logic       rsp_ready;
  logic       req_ready [NI];
  logic       rsp_valid [NI];
  logic [3:0] rsp_rdata [NI];
  logic [3:0] arr_sel   [NI];
  logic       arr_rw    [NI];
  logic [3:0] arr_in    [NI];

  int n_vec = 0;
  int n_err = 0;
  int chk_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [3:0] mem [4];
    logic [3:0] arr_out;

    // Array rows reset to row+3; a selected row is written while rw is high.
    always @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) mem[i] <= 4'(i + 3);
      end else if (arr_rw[g]) begin
        for (int i = 0; i < 4; i++) if (arr_sel[g][i]) mem[i] <= arr_in[g];
      end
    end

    always_comb begin
      arr_out = '0;
      for (int i = 0; i < 4; i++) if (arr_sel[g][i]) arr_out = mem[i];
    end

    bitcell_array_ctrl #(
      .ADDR_W(2), .DATA_W(4),
      .ACCESS_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 15))
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[g]),
      .arr_sel(arr_sel[g]), .arr_rw(arr_rw[g]), .arr_in(arr_in[g]), .arr_out(arr_out)
    );
  end

  // Continuous protocol watch: sel one-hot, rw/in frozen around any selected cycle.
  logic [3:0] p_sel [NI];
  logic       p_rw  [NI];
  logic [3:0] p_in  [NI];
  logic       p_rst = 1'b0;

  always @(posedge clk) begin
    #2;
    for (int g = 0; g < NI; g++) begin
      if (rst_n && $countones(arr_sel[g]) > 1) begin
        chk_err++;
        $display("FAIL onehot inst%0d arr_sel=%b want at most one bit", g, arr_sel[g]);
      end
      if (rst_n && p_rst && (arr_sel[g] != '0 || p_sel[g] != '0) &&
          (arr_rw[g] !== p_rw[g] || arr_in[g] !== p_in[g])) begin
        chk_err++;
        $display("FAIL stable inst%0d rw/in=%b/%h want %b/%h", g, arr_rw[g], arr_in[g], p_rw[g], p_in[g]);
      end
      p_sel[g] = arr_sel[g];
      p_rw[g]  = arr_rw[g];
      p_in[g]  = arr_in[g];
    end
    p_rst = rst_n;
  end

  // Issue one request; returns at the negedge of the first rsp_valid cycle.
  // lat is the cycle index of that response relative to the accept edge.
  task automatic send(input int g, input logic we, input logic [1:0] a, input logic [3:0] d,
                      output int waitc, output int lat, output int selw,
                      output logic [3:0] selv, output logic [3:0] rd);
    req_we = we; req_addr = a; req_wdata = d; req_valid[g] = 1'b1;
    waitc = 0;
    while (!req_ready[g] && waitc < 50) begin @(negedge clk); waitc++; end
    @(negedge clk);
    req_valid[g] = 1'b0;
    lat = 1; selw = 0; selv = '0;
    while (!rsp_valid[g] && lat < 60) begin
      if (arr_sel[g] != '0) begin selw++; selv = arr_sel[g]; end
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata[g];
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_we = 1'b1; req_addr = 2'd1; req_wdata = 4'hF;
    for (int g = 0; g < NI; g++) req_valid[g] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++; if (req_ready[0] !== 1'b1) begin n_err++; $display("FAIL rst_req_ready got %b want 1", req_ready[0]); end
      n_vec++; if (arr_sel[0] !== 4'b0) begin n_err++; $display("FAIL rst_arr_sel got %b want 0000", arr_sel[0]); end
      n_vec++; if (arr_rw[0] !== 1'b0 || arr_in[0] !== 4'h0) begin n_err++; $display("FAIL rst_arr_rw_in got %b/%h want 0/0", arr_rw[0], arr_in[0]); end
      n_vec++; if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 4'h0) begin n_err++; $display("FAIL rst_rsp got %b/%h want 0/0", rsp_valid[0], rsp_rdata[0]); end
    end
    rst_n = 1'b1;
    for (int g = 0; g < NI; g++) req_valid[g] = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      n_vec++; if (req_ready[g] !== 1'b1 || arr_rw[g] !== 1'b0) begin n_err++; $display("FAIL post_rst inst%0d ready/rw got %b/%b want 1/0", g, req_ready[g], arr_rw[g]); end
    end
  endtask

  task automatic test_write_read;
    int w, l, s; logic [3:0] sv, rd;
    rsp_ready = 1'b1;
    send(0, 1'b1, 2'd2, 4'hA, w, l, s, sv, rd);
    n_vec++; if (l != 5) begin n_err++; $display("FAIL wr_latency got %0d want 5", l); end
    n_vec++; if (s != 2 || sv !== 4'b0100) begin n_err++; $display("FAIL wr_sel got %0d x %b want 2 x 0100", s, sv); end
    n_vec++; if (rd !== 4'h0) begin n_err++; $display("FAIL wr_rdata got %h want 0", rd); end
    send(0, 1'b0, 2'd2, 4'h0, w, l, s, sv, rd);
    n_vec++; if (w != 1) begin n_err++; $display("FAIL b2b_wait got %0d want 1", w); end
    n_vec++; if (l != 5) begin n_err++; $display("FAIL rd_latency got %0d want 5", l); end
    n_vec++; if (s != 2 || sv !== 4'b0100) begin n_err++; $display("FAIL rd_sel got %0d x %b want 2 x 0100", s, sv); end
    n_vec++; if (rd !== 4'hA) begin n_err++; $display("FAIL rd_rdata got %h want a", rd); end
  endtask

  task automatic test_all_rows;
    int w, l, s; logic [3:0] sv, rd, exp_sel;
    for (int k = 0; k < 4; k++) begin
      send(0, 1'b1, 2'(k), 4'(k + 5), w, l, s, sv, rd);
      n_vec++; if (rd !== 4'h0 || l != 5) begin n_err++; $display("FAIL rows_wr%0d rdata/lat got %h/%0d want 0/5", k, rd, l); end
    end
    for (int k = 0; k < 4; k++) begin
      exp_sel = 4'b0001 << k;
      send(0, 1'b0, 2'(k), 4'h0, w, l, s, sv, rd);
      n_vec++; if (rd !== 4'(k + 5)) begin n_err++; $display("FAIL rows_rd%0d got %h want %h", k, rd, 4'(k + 5)); end
      n_vec++; if (sv !== exp_sel || s != 2 || w != 1) begin n_err++; $display("FAIL rows_sel%0d got %b x%0d wait%0d want %b x2 wait1", k, sv, s, w, exp_sel); end
    end
  endtask

  task automatic test_backpressure;
    int w, l, s, c; logic [3:0] sv, rd;
    @(negedge clk);
    rsp_ready = 1'b0;
    send(0, 1'b0, 2'd1, 4'h0, w, l, s, sv, rd);
    n_vec++; if (l != 5 || rd !== 4'h6) begin n_err++; $display("FAIL bp_first got lat%0d %h want lat5 6", l, rd); end
    req_we = 1'b1; req_addr = 2'd0; req_wdata = 4'hF; req_valid[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_vec++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 4'h6 || req_ready[0] !== 1'b0) begin
        n_err++; $display("FAIL bp_hold%0d valid/rdata/ready got %b/%h/%b want 1/6/0", i, rsp_valid[0], rsp_rdata[0], req_ready[0]);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin n_err++; $display("FAIL bp_release valid/ready got %b/%b want 0/1", rsp_valid[0], req_ready[0]); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    n_vec++; if (req_ready[0] !== 1'b0 || arr_rw[0] !== 1'b1 || arr_in[0] !== 4'hF) begin n_err++; $display("FAIL bp_next_accept ready/rw/in got %b/%b/%h want 0/1/f", req_ready[0], arr_rw[0], arr_in[0]); end
    c = 0;
    while (!rsp_valid[0] && c < 20) begin @(negedge clk); c++; end
    n_vec++; if (c != 4) begin n_err++; $display("FAIL bp_next_done got %0d cycles want 4", c); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    req_we = 1'b1; req_addr = 2'd3; req_wdata = 4'h5; req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    n_vec++; if (arr_sel[0] !== 4'b1000 || arr_rw[0] !== 1'b1) begin n_err++; $display("FAIL mid_access sel/rw got %b/%b want 1000/1", arr_sel[0], arr_rw[0]); end
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (arr_sel[0] !== 4'b0 || rsp_valid[0] !== 1'b0 || arr_rw[0] !== 1'b0) begin n_err++; $display("FAIL mid_abort sel/valid/rw got %b/%b/%b want 0000/0/0", arr_sel[0], rsp_valid[0], arr_rw[0]); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready[0] !== 1'b1) begin n_err++; $display("FAIL mid_ready got %b want 1", req_ready[0]); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_vec++; if (rsp_valid[0] !== 1'b0 || arr_sel[0] !== 4'b0) begin n_err++; $display("FAIL mid_quiet%0d valid/sel got %b/%b want 0/0000", i, rsp_valid[0], arr_sel[0]); end
    end
  endtask

  task automatic test_access_len(input int g, input int ac);
    int w, l, s; logic [3:0] sv, rd;
    rsp_ready = 1'b1;
    send(g, 1'b0, 2'd0, 4'h0, w, l, s, sv, rd);
    n_vec++; if (l != ac + 3 || s != ac) begin n_err++; $display("FAIL ac%0d_first lat/width got %0d/%0d want %0d/%0d", ac, l, s, ac + 3, ac); end
    n_vec++; if (rd !== 4'h3 || sv !== 4'b0001) begin n_err++; $display("FAIL ac%0d_first rdata/sel got %h/%b want 3/0001", ac, rd, sv); end
    send(g, 1'b0, 2'd3, 4'h0, w, l, s, sv, rd);
    n_vec++; if (w != 1 || l != ac + 3 || s != ac) begin n_err++; $display("FAIL ac%0d_b2b wait/lat/width got %0d/%0d/%0d want 1/%0d/%0d", ac, w, l, s, ac + 3, ac); end
    n_vec++; if (rd !== 4'h6 || sv !== 4'b1000) begin n_err++; $display("FAIL ac%0d_b2b rdata/sel got %h/%b want 6/1000", ac, rd, sv); end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_we = 1'b0; req_addr = '0; req_wdata = '0;
    for (int g = 0; g < NI; g++) req_valid[g] = 1'b0;
    test_reset;
    test_write_read;
    test_all_rows;
    test_backpressure;
    test_reset_mid;
    test_access_len(1, 1);
    test_access_len(2, 15);
    @(negedge clk);
    n_vec++; if (chk_err != 0) begin n_err++; $display("FAIL protocol_watch got %0d violations want 0", chk_err); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bitcell_array_ctrl.md
# bitcell_array_ctrl

Sequencing controller that sits directly upstream of the bitcell memory array and drives its `sel`, `rw` and `in` lines. It accepts single-word read/write requests on a valid/ready handshake, decodes the address to a one-hot word select, and runs a fixed setup/access/hold sequence so that `in` and `rw` are stable whenever a bitcell is selected. Read data is captured from the array's `out` lines and returned on a response handshake.

## Interface

Parameters:
- `ADDR_W`, default 2: address width; the array has `WORDS = 2**ADDR_W` rows.
- `DATA_W`, default 4: bits per word, equal to bitcells per row.
- `ACCESS_CYCLES`, default 2: number of cycles `arr_sel` is held high; legal range 1..15.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out DATA_W: read data; 0 for write responses.
- `arr_sel` out WORDS: one-hot row select to the bitcells' `sel`.
- `arr_rw` out 1: to the bitcells' `rw`; 1 = write, 0 = read.
- `arr_in` out DATA_W: to the bitcells' `in`, shared by all rows.
- `arr_out` in DATA_W: the bitcells' `out` for the selected row.

## Operation

- States: IDLE, SETUP, ACCESS, HOLD, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch `req_we`, `req_addr` and `req_wdata` (write only) and go to SETUP.
- SETUP (1 cycle): `arr_rw` = latched we, `arr_in` = latched wdata (0 for reads), `arr_sel` = 0. Go to ACCESS.
- ACCESS (`ACCESS_CYCLES` cycles): `arr_sel` = one-hot of the latched address; `arr_rw` and `arr_in` unchanged. A 4-bit down-counter loaded with `ACCESS_CYCLES-1` on entry sets the duration. For reads, `arr_out` is captured into the rdata register on the last ACCESS cycle. Go to HOLD.
- HOLD (1 cycle): `arr_sel` = 0; `arr_rw` and `arr_in` held. Go to RESP.
- RESP: `rsp_valid`=1, `rsp_rdata` = captured data for a read, 0 for a write. On `rsp_ready`, go to IDLE, set `arr_rw`=0 and `arr_in`=0.
- `req_ready` is 0 in every state except IDLE. There is only one outstanding transaction.
- `arr_sel` is never multi-hot and is only non-zero in ACCESS.
- `arr_rw` and `arr_in` never change while any `arr_sel` bit is high.

## Timing

- Reset (`rst_n`=0 at a rising edge): state IDLE. Outputs the cycle after: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `arr_sel`=0, `arr_rw`=0, `arr_in`=0. Counter and latches are cleared.
- Reset mid-transaction: it aborts at the same edge. `arr_sel` is 0 the next cycle and no response is issued. A write aborted in ACCESS leaves the row content undefined.
- Latency for a handshake at edge T:
  - SETUP in cycle T+1.
  - ACCESS in cycles T+2 .. T+1+ACCESS_CYCLES.
  - HOLD in cycle T+2+ACCESS_CYCLES.
  - `rsp_valid` first high in cycle T+3+ACCESS_CYCLES. This is 5 cycles for the default.
- With `rsp_ready` held at 1, a back-to-back request is accepted in the cycle after the response handshake. Throughput is one transaction per ACCESS_CYCLES+4 cycles.
- `rsp_valid` and `rsp_rdata` stay stable while `rsp_ready`=0, for an unbounded stall.
- `req_*` inputs are ignored outside IDLE. A `req_valid` that stays high is accepted once per IDLE visit.
- Address `WORDS-1` selects `arr_sel[WORDS-1]`. There is no out-of-range case.

## Test plan

- Reset: hold `rst_n`=0 for 2 cycles while driving `req_valid`=1 → `req_ready`=1, `arr_sel`=0, `arr_rw`=0, `rsp_valid`=0, and no transaction is accepted until after release.
- Write then read, defaults: write addr 2, data 4'hA, then read addr 2 with a behavioural array → `arr_sel`=4'b0100 for exactly 2 cycles each time, write `rsp_rdata`=0, read `rsp_rdata`=4'hA, `rsp_valid` 5 cycles after each accept.
- All rows: write addr k with data k+5 for k=0..3, then read all four → returns 5, 6, 7, 8. `arr_sel` is one-hot every cycle, and the checker asserts `arr_rw`/`arr_in` are stable whenever `arr_sel`≠0.
- Response backpressure: read addr 1 with `rsp_ready`=0 for 7 cycles → `rsp_valid` and `rsp_rdata` hold, `req_ready`=0 throughout, and the next request is accepted only after the `rsp_ready` handshake.
- Reset mid-access: assert `rst_n`=0 during the first ACCESS cycle of a write → `arr_sel`=0 the next cycle, no `rsp_valid`, and `req_ready`=1 after release.
- `ACCESS_CYCLES`=1 and 15: back-to-back reads → `arr_sel` pulse width is 1 and 15 cycles respectively, and response latency is 4 and 18 cycles.
